// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between the fetch stage and the memory controller.
// A hit returns its instruction one cycle after the request is accepted. A miss refills the
// whole line one word at a time, installs it, and then returns the requested word.
// The global rdy input freezes every register. flush abandons the request in flight.
module icache_direct #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned WORD_BITS  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy_i,
   input  logic        fetch_enable_i,
   input  logic [31:0] fetch_pc_i,
   output logic [31:0] instr_out_o,
   output logic        fetch_success_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_done_i
);

   localparam int unsigned Lines   = 1 << INDEX_BITS;
   localparam int unsigned Words   = 1 << WORD_BITS;
   localparam int unsigned IdxLsb  = WORD_BITS + 2;
   localparam int unsigned TagLsb  = INDEX_BITS + WORD_BITS + 2;
   localparam int unsigned TagBits = 32 - TagLsb;

   typedef enum logic [1:0] {StIdle, StRefill, StRespond, StDrain} state_e;

   // Cache storage. Only the valid bits need a reset value.
   logic [Lines-1:0]   valid_q;
   logic [TagBits-1:0] tag_q  [Lines];
   logic [31:0]        data_q [Lines][Words];

   // Words collected during a refill. The final word bypasses this buffer.
   logic [31:0] buf_q [Words];
   logic [31:0] buf_d [Words];
   logic [31:0] fill_line [Words];

   state_e                state_q, state_d;
   logic [WORD_BITS-1:0]  cnt_q, cnt_d;
   logic                  req_q, req_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           instr_q, instr_d;
   logic                  succ_q, succ_d;
   logic [TagBits-1:0]    lat_tag_q, lat_tag_d;
   logic [INDEX_BITS-1:0] lat_idx_q, lat_idx_d;
   logic [WORD_BITS-1:0]  lat_off_q, lat_off_d;
   logic                  install;

   // Fields of the incoming fetch address.
   logic [WORD_BITS-1:0]  req_off;
   logic [INDEX_BITS-1:0] req_idx;
   logic [TagBits-1:0]    req_tag;
   logic                  req_hit;
   logic                  accept;
   logic [WORD_BITS-1:0]  cnt_inc;
   logic                  cnt_last;
   logic                  unused_pc;

   assign req_off   = fetch_pc_i[IdxLsb-1:2];
   assign req_idx   = fetch_pc_i[TagLsb-1:IdxLsb];
   assign req_tag   = fetch_pc_i[31:TagLsb];
   assign unused_pc = ^fetch_pc_i[1:0];

   assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   // No request is accepted while a response is still visible, because the fetch PC has not
   // advanced yet.
   assign accept   = (state_q == StIdle) && fetch_enable_i && !flush_i && !succ_q;
   assign cnt_inc  = cnt_q + WORD_BITS'(1);
   assign cnt_last = (cnt_q == WORD_BITS'(Words - 1));

   // Assemble the line to install: buffered words, plus the word arriving on this edge.
   always_comb begin
      for (int w = 0; w < int'(Words); w++) begin
         fill_line[w] = (WORD_BITS'(w) == cnt_q) ? mem_data_i : buf_q[w];
      end
   end

   // Next-state logic for the controller, the memory request and the fetch response.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      addr_d    = addr_q;
      instr_d   = instr_q;
      succ_d    = 1'b0;
      lat_tag_d = lat_tag_q;
      lat_idx_d = lat_idx_q;
      lat_off_d = lat_off_q;
      buf_d     = buf_q;
      install   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               lat_tag_d = req_tag;
               lat_idx_d = req_idx;
               lat_off_d = req_off;
               if (req_hit) begin
                  instr_d = data_q[req_idx][req_off];
                  succ_d  = 1'b1;
               end else begin
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  addr_d  = {req_tag, req_idx, {WORD_BITS{1'b0}}, 2'b00};
                  state_d = StRefill;
               end
            end
         end

         StRefill: begin
            if (req_q) begin
               if (mem_done_i) begin
                  // The word is kept even under flush. A completed line is still installed.
                  buf_d[cnt_q] = mem_data_i;
                  req_d        = 1'b0;
                  if (cnt_last) begin
                     install = 1'b1;
                     state_d = flush_i ? StIdle : StRespond;
                  end else begin
                     cnt_d  = cnt_inc;
                     addr_d = {lat_tag_q, lat_idx_q, cnt_inc, 2'b00};
                     if (flush_i) begin
                        state_d = StIdle;
                     end
                  end
               end else if (flush_i) begin
                  // The memory request is already out, so let it finish and discard the data.
                  state_d = StDrain;
               end
            end else begin
               // One-cycle low gap between word requests.
               if (flush_i) begin
                  state_d = StIdle;
               end else begin
                  req_d = 1'b1;
               end
            end
         end

         StRespond: begin
            state_d = StIdle;
            if (!flush_i) begin
               instr_d = data_q[lat_idx_q][lat_off_q];
               succ_d  = 1'b1;
            end
         end

         StDrain: begin
            if (mem_done_i) begin
               req_d   = 1'b0;
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      if (flush_i) begin
         succ_d = 1'b0;
      end
   end

   // Control registers: reset has priority, and rdy=0 freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         valid_q   <= '0;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         addr_q    <= '0;
         instr_q   <= '0;
         succ_q    <= 1'b0;
         lat_tag_q <= '0;
         lat_idx_q <= '0;
         lat_off_q <= '0;
      end else if (rdy_i) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         instr_q   <= instr_d;
         succ_q    <= succ_d;
         lat_tag_q <= lat_tag_d;
         lat_idx_q <= lat_idx_d;
         lat_off_q <= lat_off_d;
         if (install) begin
            valid_q[lat_idx_q] <= 1'b1;
         end
      end
   end

   // Tag, data and refill buffer storage, with no reset; the valid bits guard the contents.
   always_ff @(posedge clk) begin
      if (!rst && rdy_i) begin
         buf_q <= buf_d;
         if (install) begin
            tag_q[lat_idx_q] <= lat_tag_q;
            for (int w = 0; w < int'(Words); w++) begin
               data_q[lat_idx_q][w] <= fill_line[w];
            end
         end
      end
   end

   assign instr_out_o     = instr_q;
   assign fetch_success_o = succ_q;
   assign mem_req_o       = req_q;
   assign mem_addr_o      = addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct. A memory responder answers each word request three
// cycles after it is raised, and freezes together with the cache while rdy is low.
module tb_icache_direct;

   logic        clk;
   logic        rst;
   logic        rdy_i;
   logic        fetch_enable_i;
   logic [31:0] fetch_pc_i;
   logic [31:0] instr_out_o;
   logic        fetch_success_o;
   logic        flush_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_i;
   logic        mem_done_i;

   icache_direct #(
      .INDEX_BITS(6),
      .WORD_BITS (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy_i          (rdy_i),
      .fetch_enable_i (fetch_enable_i),
      .fetch_pc_i     (fetch_pc_i),
      .instr_out_o    (instr_out_o),
      .fetch_success_o(fetch_success_o),
      .flush_i        (flush_i),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_i     (mem_data_i),
      .mem_done_i     (mem_done_i)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          n_req = 0;
   int          succ_cnt = 0;
   int          wait_cnt = 0;
   logic [31:0] last_instr = '0;
   logic [31:0] mem_base = '0;
   logic [31:0] addr_log[$];
   logic        req_prev = 1'b0;
   logic        s_rst, s_rdy, s_req, s_done;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge monitor and memory responder. Values are sampled before the edge updates, and the
   // responder drives 1 time unit after the edge.
   initial begin
      mem_done_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(posedge clk);
         s_rst  = rst;
         s_rdy  = rdy_i;
         s_req  = mem_req_o;
         s_done = mem_done_i;
         if (!s_rst && s_req && !req_prev) begin
            n_req++;
            addr_log.push_back(mem_addr_o);
         end
         req_prev = s_req;
         if (!s_rst && s_rdy && fetch_success_o) begin
            succ_cnt++;
            last_instr = instr_out_o;
         end
         #1;
         if (s_rst) begin
            mem_done_i = 1'b0;
            wait_cnt   = 0;
         end else if (s_rdy) begin
            if (s_done) begin
               mem_done_i = 1'b0;
               wait_cnt   = 0;
            end else if (s_req) begin
               wait_cnt++;
               if (wait_cnt == 3) begin
                  mem_done_i = 1'b1;
                  mem_data_i = mem_base + 32'(mem_addr_o[3:2]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [31:0] pc);
      fetch_enable_i = 1'b1;
      fetch_pc_i     = pc;
      tick();
      fetch_enable_i = 1'b0;
   endtask

   task automatic wait_success(input string tag, input int target);
      for (int i = 0; i < 400; i++) begin
         if (succ_cnt >= target) break;
         tick();
      end
      check({tag, "_pulse"}, succ_cnt, target);
   endtask

   task automatic wait_req(input string tag, input int target);
      for (int i = 0; i < 100; i++) begin
         if (n_req >= target) break;
         tick();
      end
      check({tag, "_reqs"}, n_req, target);
   endtask

   // Full miss: four word requests at the line base upward, then one response.
   task automatic do_miss(input string tag, input logic [31:0] pc, input logic [31:0] base,
                          input logic [31:0] exp_instr);
      int r0;
      int s0;
      logic [31:0] line;
      line     = pc & ~32'hF;
      mem_base = base;
      r0       = n_req;
      s0       = succ_cnt;
      addr_log.delete();
      issue(pc);
      wait_success(tag, s0 + 1);
      check({tag, "_instr"}, last_instr, exp_instr);
      check({tag, "_nreq"}, n_req - r0, 4);
      for (int w = 0; w < 4; w++) begin
         check({tag, "_addr"}, addr_log[w], line + 32'(4 * w));
      end
      tick();
      tick();
      check({tag, "_once"}, succ_cnt - s0, 1);
   endtask

   initial begin
      int r0;
      int s0;
      rst            = 1'b1;
      rdy_i          = 1'b1;
      fetch_enable_i = 1'b0;
      fetch_pc_i     = '0;
      flush_i        = 1'b0;
      repeat (3) tick();
      check("rst_succ", fetch_success_o, 1'b0);
      check("rst_req", mem_req_o, 1'b0);
      check("rst_instr", instr_out_o, 32'h0);
      check("rst_addr", mem_addr_o, 32'h0);
      rst = 1'b0;
      tick();

      // Cold miss followed by a hit in the same line.
      do_miss("cold", 32'h0000_0104, 32'hA0, 32'hA1);
      r0 = n_req;
      s0 = succ_cnt;
      issue(32'h0000_0108);
      check("hit_succ", fetch_success_o, 1'b1);
      check("hit_instr", instr_out_o, 32'hA2);
      check("hit_req", mem_req_o, 1'b0);
      tick();
      tick();
      check("hit_noreq", n_req - r0, 0);
      check("hit_once", succ_cnt - s0, 1);

      // Enable held for four edges yields one instruction per two cycles.
      s0             = succ_cnt;
      fetch_enable_i = 1'b1;
      fetch_pc_i     = 32'h0000_010C;
      repeat (4) tick();
      fetch_enable_i = 1'b0;
      tick();
      check("thru_pulses", succ_cnt - s0, 2);
      check("thru_instr", last_instr, 32'hA3);
      tick();

      // Conflict on index 0x10 evicts the 0x100 line.
      do_miss("conflict", 32'h0000_0504, 32'hB0, 32'hB1);
      do_miss("refetch", 32'h0000_0104, 32'hA0, 32'hA1);

      // Flush while the second word request is outstanding.
      do_miss("evict", 32'h0000_0500, 32'hB0, 32'hB0);
      mem_base = 32'hA0;
      r0       = n_req;
      s0       = succ_cnt;
      issue(32'h0000_0100);
      wait_req("flush", r0 + 2);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("drain_req", mem_req_o, 1'b1);
      check("drain_addr", mem_addr_o, 32'h104);
      for (int i = 0; i < 50; i++) begin
         if (!mem_req_o) break;
         tick();
      end
      check("drain_done", mem_req_o, 1'b0);
      repeat (10) tick();
      check("flush_nreq", n_req - r0, 2);
      check("flush_nosucc", succ_cnt - s0, 0);
      do_miss("after_flush", 32'h0000_0100, 32'hA0, 32'hA0);

      // Synchronous reset mid-refill drops the request and clears all valid bits.
      do_miss("fill200", 32'h0000_0200, 32'hC0, 32'hC0);
      mem_base = 32'hD0;
      r0       = n_req;
      issue(32'h0000_0304);
      wait_req("rstmid", r0 + 2);
      rst = 1'b1;
      tick();
      check("rstmid_req", mem_req_o, 1'b0);
      check("rstmid_succ", fetch_success_o, 1'b0);
      rst = 1'b0;
      repeat (3) tick();
      check("rstmid_idle", mem_req_o, 1'b0);
      check("rstmid_nreq", n_req - r0, 2);
      do_miss("after_rst", 32'h0000_0100, 32'hA0, 32'hA0);

      // rdy stall across a mem_done pulse.
      mem_base = 32'hC0;
      r0       = n_req;
      s0       = succ_cnt;
      addr_log.delete();
      issue(32'h0000_0200);
      for (int i = 0; i < 50; i++) begin
         if (mem_done_i) break;
         tick();
      end
      check("stall_seen_done", mem_done_i, 1'b1);
      rdy_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_req", mem_req_o, 1'b1);
         check("stall_addr", mem_addr_o, 32'h200);
      end
      rdy_i = 1'b1;
      wait_success("stall_miss", s0 + 1);
      check("stall_instr", last_instr, 32'hC0);
      check("stall_nreq", n_req - r0, 4);
      for (int w = 0; w < 4; w++) begin
         check("stall_addr_seq", addr_log[w], 32'h200 + 32'(4 * w));
      end
      tick();
      tick();
      issue(32'h0000_0204);
      check("stall_w1_succ", fetch_success_o, 1'b1);
      check("stall_w1_instr", instr_out_o, 32'hC1);
      tick();
      tick();

      // rdy stall across a pending hit response: the response is held, then counted once.
      s0 = succ_cnt;
      issue(32'h0000_0208);
      check("hstall_succ", fetch_success_o, 1'b1);
      check("hstall_instr", instr_out_o, 32'hC2);
      rdy_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hstall_hold", fetch_success_o, 1'b1);
      end
      rdy_i = 1'b1;
      tick();
      check("hstall_drop", fetch_success_o, 1'b0);
      tick();
      check("hstall_once", succ_cnt - s0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
